// File: rtl/i2s_rx.sv
// i2s_rx: standard-I2S capture for the alarm audio path.
// S_CLK, LR_CLK and Sin are oversampled in the CLK domain. Each S_CLK
// rising edge shifts one data bit in. A change of word select marks a word
// boundary. Complete left/right pairs are presented with a one-cycle valid
// strobe. Word boundaries with the wrong bit count raise frame_err.

module i2s_rx #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              S_CLK,
  input  logic              LR_CLK,
  input  logic              Sin,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid,
  output logic              frame_err
);

  // The bit counter has to hold DATA_W+1. That value marks an over-long word.
  localparam int                CNT_W   = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W:0]    N_GOOD  = (CNT_W + 1)'(DATA_W);

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } state_t;

  // Synchronizer stages. LR_CLK and Sin have the same depth as S_CLK's s2,
  // so ws/sd stay aligned with the edge detected on S_CLK.
  logic sck_s1, sck_s2, sck_s3;
  logic ws_s1,  ws_s2;
  logic sd_s1,  sd_s2;

  logic sck_rise;
  logic ws;
  logic sd;

  // Only the low DATA_W-1 bits are kept. The oldest bit in a full-width
  // register would be shifted out before any word could use it.
  logic [DATA_W-2:0] shreg;
  logic [CNT_W-1:0]  bitcnt;
  logic              ws_prev;
  logic              left_ok;

  logic              boundary;
  logic [CNT_W:0]    bit_total;
  logic              word_good;
  logic [DATA_W-1:0] word;

  state_t state_q, state_d;
  logic   synced;

  // Bring the asynchronous link pins into the CLK domain.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
      sd_s1  <= 1'b0;
      sd_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sck_s1 <= S_CLK;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= LR_CLK;
      ws_s2  <= ws_s1;
      sd_s1  <= Sin;
      sd_s2  <= sd_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign ws       = ws_s2;
  assign sd       = sd_s2;

  // A word-select change marks a word boundary. The bit sampled on this edge
  // is the LSB of the word for channel ws_prev.
  assign boundary  = sck_rise && (ws != ws_prev);
  assign bit_total = {1'b0, bitcnt} + (CNT_W + 1)'(1);
  assign word_good = (bit_total == N_GOOD);
  assign word      = {shreg, sd};

  // Alignment state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= UNSYNCED;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave UNSYNCED on the first boundary. Only reset returns to UNSYNCED.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      UNSYNCED: if (boundary) state_d = SYNCED;
      SYNCED:   state_d = SYNCED;
      default:  state_d = UNSYNCED;
    endcase
  end

  // State decode used by the datapath.
  always_comb begin
    synced = 1'b0;
    if (state_q == SYNCED) synced = 1'b1;
  end

  // Shift, count and latch words on each S_CLK rise. valid and frame_err
  // are pulses that default low every cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      ws_prev    <= 1'b0;
      left_ok    <= 1'b0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (sck_rise) begin
        shreg   <= word[DATA_W-2:0];
        ws_prev <= ws;
        if (boundary) begin
          bitcnt <= '0;
          // The first boundary after reset only aligns. The partial word
          // before it is dropped without an error.
          if (synced) begin
            if (word_good) begin
              if (!ws_prev) begin
                left_data <= word;
                left_ok   <= 1'b1;
              end else begin
                // A right word without a good left word updates right_data
                // but does not form a pair.
                right_data <= word;
                valid      <= left_ok;
                left_ok    <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              left_ok   <= 1'b0;
            end
          end
        end else if (bitcnt != CNT_MAX) begin
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives I2S frames at CLK = 8x S_CLK. A scoreboard queue holds
// the expected valid/frame_err events, in order. A monitor pops and checks
// each event when the receiver produces it.

module tb_i2s_rx;

  localparam int W = 16;

  logic         CLK;
  logic         reset;
  logic         S_CLK;
  logic         LR_CLK;
  logic         Sin;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         valid;
  logic         frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rise = 0;

  typedef struct {
    bit           is_valid;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  typedef struct {
    int           lbits;
    logic [W-1:0] l;
    int           rbits;
    logic [W-1:0] r;
    bit           l_err;
    bit           r_err;
    bit           v;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   valid_cycles[$];
  vec_t vecs[8];

  i2s_rx #(.DATA_W(W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .S_CLK      (S_CLK),
    .LR_CLK     (LR_CLK),
    .Sin        (Sin),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // One serial bit: data changes with S_CLK low, then S_CLK rises 4 CLK later.
  task automatic send_bit(input logic ws_v, input logic sd_v);
    S_CLK  = 1'b0;
    LR_CLK = ws_v;
    Sin    = sd_v;
    repeat (4) @(negedge CLK);
    S_CLK     = 1'b1;
    last_rise = cyc;
    repeat (4) @(negedge CLK);
  endtask

  // An nbits-long word for channel ch, MSB first. The final (LSB) bit goes
  // out with word select already at the other channel (one-bit delay).
  task automatic send_word(input logic ch, input logic [W-1:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i == nbits - 1) ? ~ch : ch, (i < W) ? data[W-1-i] : 1'b0);
    end
  endtask

  task automatic push_valid(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_t e;
    e.is_valid = 1'b1;
    e.l = l;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_valid = 1'b0;
    e.l = '0;
    e.r = '0;
    exp_q.push_back(e);
  endtask

  // A partial left word to align, then a right filler word. The filler
  // updates right_data but does not form a pair.
  task automatic align(input int partial_bits, input logic [W-1:0] filler);
    send_word(1'b0, 16'hFFFF, partial_bits);
    send_word(1'b1, filler, W);
  endtask

  // Monitor: every valid/frame_err pulse must match the head of the queue
  // and arrive 3 CLK after the S_CLK rise that caused it.
  always @(negedge CLK) begin
    if (reset) begin
      if (valid && frame_err) check("valid_frame_err_exclusive", 32'(valid & frame_err), 32'd0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind_valid", 32'(valid), 32'(mon_e.is_valid));
          check("event_latency", 32'(cyc - last_rise), 32'd3);
          if (valid) begin
            check("pair_left_data", 32'(left_data), 32'(mon_e.l));
            check("pair_right_data", 32'(right_data), 32'(mon_e.r));
            valid_cycles.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // lbits, left, rbits, right, l_err, r_err, valid, held left, held right
    vecs[0] = '{16, 16'hDB6E, 16, 16'h1234, 1'b0, 1'b0, 1'b1, 16'hDB6E, 16'h1234};
    vecs[1] = '{15, 16'h3333, 16, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'hDB6E, 16'hABCD};
    vecs[2] = '{16, 16'hAAAA, 16, 16'h5555, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h5555};
    vecs[3] = '{16, 16'h1111, 17, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h5555};
    vecs[4] = '{16, 16'hC3C3, 16, 16'h3C3C, 1'b0, 1'b0, 1'b1, 16'hC3C3, 16'h3C3C};
    vecs[5] = '{20, 16'h9999, 16, 16'h7777, 1'b1, 1'b0, 1'b0, 16'hC3C3, 16'h7777};
    vecs[6] = '{16, 16'h0001, 16, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h8000};
    vecs[7] = '{16, 16'hFFFF, 16, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000};

    reset  = 1'b0;
    S_CLK  = 1'b0;
    LR_CLK = 1'b0;
    Sin    = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_left_data", 32'(left_data), 32'd0);
    check("reset_right_data", 32'(right_data), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    @(negedge CLK);

    // Power-up alignment: 7-bit partial word, filler, then the first pair.
    align(7, 16'h5A5A);
    check("align_filler_right", 32'(right_data), 32'h5A5A);
    check("align_left_untouched", 32'(left_data), 32'd0);
    push_valid(16'hAAAA, 16'h5555);
    send_word(1'b0, 16'hAAAA, W);
    send_word(1'b1, 16'h5555, W);
    check("first_pair_left", 32'(left_data), 32'hAAAA);
    check("first_pair_right", 32'(right_data), 32'h5555);

    // Vector table: normal, short, long and saturated words in one stream.
    foreach (vecs[i]) begin
      if (vecs[i].l_err) push_err();
      if (vecs[i].r_err) push_err();
      if (vecs[i].v) push_valid(vecs[i].exp_l, vecs[i].exp_r);
      send_word(1'b0, vecs[i].l, vecs[i].lbits);
      send_word(1'b1, vecs[i].r, vecs[i].rbits);
      check($sformatf("vec%0d_left_data", i), 32'(left_data), 32'(vecs[i].exp_l));
      check($sformatf("vec%0d_right_data", i), 32'(right_data), 32'(vecs[i].exp_r));
    end
    check("queue_drained_after_table", 32'(exp_q.size()), 32'd0);

    // Reset during bit 9 of a left word.
    for (int i = 0; i < 8; i++) send_bit(1'b0, i[0]);
    S_CLK  = 1'b0;
    LR_CLK = 1'b0;
    Sin    = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("midreset_left_data", 32'(left_data), 32'd0);
    check("midreset_right_data", 32'(right_data), 32'd0);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    repeat (4) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    align(5, 16'h6666);
    push_valid(16'h0F0F, 16'hF0F0);
    send_word(1'b0, 16'h0F0F, W);
    send_word(1'b1, 16'hF0F0, W);
    check("post_reset_left", 32'(left_data), 32'h0F0F);
    check("post_reset_right", 32'(right_data), 32'hF0F0);

    // Back-to-back pairs: one valid every 2*W S_CLK periods (8 CLK each).
    valid_cycles.delete();
    for (int p = 0; p < 4; p++) begin
      logic [W-1:0] l_w;
      logic [W-1:0] r_w;
      l_w = 16'h1357 + 16'(p * 16'h1111);
      r_w = 16'hECA8 - 16'(p * 16'h0202);
      push_valid(l_w, r_w);
      send_word(1'b0, l_w, W);
      send_word(1'b1, r_w, W);
    end
    check("b2b_valid_count", 32'(valid_cycles.size()), 32'd4);
    for (int i = 1; i < valid_cycles.size(); i++) begin
      check($sformatf("b2b_spacing_%0d", i), 32'(valid_cycles[i] - valid_cycles[i-1]), 32'(2 * W * 8));
    end

    // Idle: S_CLK stopped, outputs must hold and no events may appear.
    repeat (100) @(negedge CLK);
    check("idle_left_hold", 32'(left_data), 32'(16'h1357 + 16'(3 * 16'h1111)));
    check("idle_right_hold", 32'(right_data), 32'(16'hECA8 - 16'(3 * 16'h0202)));
    check("queue_drained_final", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
